// File: rtl/cmd_pkg.sv
// Shared definitions for the RS422 command responder: opcodes, response bytes, FSM states.
// The optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
package cmd_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_PING  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [7:0] PING_RESP = 8'hA5;
  localparam logic [7:0] NAK       = 8'hEE;

  typedef enum logic [1:0] {
    StIdle,
    StWrHi,
    StWrLo,
    StResp
  } state_e;

  function automatic logic is_ctrl_addr(input logic [3:0] addr, input int unsigned nctrl);
    return 32'(addr) < nctrl;
  endfunction

endpackage

// File: rtl/cmd_responder_if.sv
// Byte link between serialrx/serialtx and the command responder.
interface cmd_responder_if;
  logic       rx_strobe;
  logic [7:0] rx_byte;
  logic       tx_xmit;
  logic [7:0] tx_char;

  modport master (
    output rx_strobe,
    output rx_byte,
    input  tx_xmit,
    input  tx_char
  );

  modport slave (
    input  rx_strobe,
    input  rx_byte,
    output tx_xmit,
    output tx_char
  );
endinterface

// File: rtl/cmd_regbank.sv
// Control register bank with a single write port and a combinational read mux that also
// covers the read-only status words; unmapped addresses read zero.
module cmd_regbank #(
  parameter int unsigned NCTRL = 8,
  parameter int unsigned NSTAT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [3:0]           waddr,
  input  logic [15:0]          wdata,
  input  logic [3:0]           raddr,
  input  logic [16*NSTAT-1:0]  status_in,
  output logic [16*NCTRL-1:0]  ctrl_regs,
  output logic [15:0]          rdata
);

  logic [16*NCTRL-1:0] ctrl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (we) begin
      for (int unsigned k = 0; k < NCTRL; k++) begin
        if (32'(waddr) == k) ctrl_q[16*k +: 16] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < NCTRL; k++) begin
      if (32'(raddr) == k) rdata = ctrl_q[16*k +: 16];
    end
    for (int unsigned k = 0; k < NSTAT; k++) begin
      if (32'(raddr) == NCTRL + k) rdata = status_in[16*k +: 16];
    end
  end

  assign ctrl_regs = ctrl_q;

endmodule

// File: rtl/cmd_responder.sv
// Byte-level command parser/responder for the cRIO RS422 link (READ/WRITE/PING).
// Define CMD_TIMEOUT_EN to abort stalled WRITE commands after TIMEOUT idle cycles.
module cmd_responder
  import cmd_pkg::*;
#(
  parameter int unsigned NCTRL = 8,
  parameter int unsigned NSTAT = 8
`ifdef CMD_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 65535
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  cmd_responder_if.slave      link,
  input  logic [16*NSTAT-1:0] status_in,
  output logic [16*NCTRL-1:0] ctrl_regs,
  output logic                wr_strobe,
  output logic [3:0]          wr_addr
);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  resp_q [3];
  logic [7:0]  resp_d [3];
  logic [1:0]  last_q, last_d;
  logic [1:0]  idx_q, idx_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic        we;
  logic [15:0] rdata;
  logic [1:0]  op;
  logic        rsvd_ok;

  assign op      = link.rx_byte[7:6];
  assign rsvd_ok = (link.rx_byte[5:4] == 2'b00);

  cmd_regbank #(
    .NCTRL (NCTRL),
    .NSTAT (NSTAT)
  ) u_regbank (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (cmd_q[3:0]),
    .wdata     ({hi_q, link.rx_byte}),
    .raddr     (link.rx_byte[3:0]),
    .status_in (status_in),
    .ctrl_regs (ctrl_regs),
    .rdata     (rdata)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            in_write;

  assign in_write = (state_q == StWrHi) || (state_q == StWrLo);
  assign tmo_d    = (in_write && !link.rx_strobe) ? tmo_q + 1'b1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      hi_q        <= '0;
      last_q      <= '0;
      idx_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int i = 0; i < 3; i++) resp_q[i] <= '0;
    end else begin
      cmd_q       <= cmd_d;
      hi_q        <= hi_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      resp_q      <= resp_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    hi_d        = hi_q;
    resp_d      = resp_q;
    last_d      = last_q;
    idx_d       = idx_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    we          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (link.rx_strobe) begin
          if (rsvd_ok && op == OP_WRITE) begin
            cmd_d   = link.rx_byte;
            state_d = StWrHi;
          end else begin
            state_d   = StResp;
            idx_d     = '0;
            last_d    = 2'd0;
            resp_d[0] = NAK;
            if (rsvd_ok && op == OP_READ) begin
              // Read data is captured now; later status changes must not leak in.
              resp_d[0] = link.rx_byte;
              resp_d[1] = rdata[15:8];
              resp_d[2] = rdata[7:0];
              last_d    = 2'd2;
            end else if (rsvd_ok && op == OP_PING) begin
              resp_d[0] = PING_RESP;
            end
          end
        end
      end
      StWrHi: begin
        if (link.rx_strobe) begin
          hi_d    = link.rx_byte;
          state_d = StWrLo;
        end
      end
      StWrLo: begin
        if (link.rx_strobe) begin
          state_d = StResp;
          idx_d   = '0;
          last_d  = 2'd0;
          if (is_ctrl_addr(cmd_q[3:0], NCTRL)) begin
            we          = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = cmd_q[3:0];
            resp_d[0]   = cmd_q;
          end else begin
            resp_d[0] = NAK;
          end
        end
      end
      StResp: begin
        if (idx_q == last_q) state_d = StIdle;
        else                 idx_d   = idx_q + 2'd1;
      end
      default: state_d = StIdle;
    endcase

`ifdef CMD_TIMEOUT_EN
    if (in_write && !link.rx_strobe && tmo_q == TmoW'(TIMEOUT)) begin
      state_d   = StResp;
      idx_d     = '0;
      last_d    = 2'd0;
      resp_d[0] = NAK;
    end
`endif
  end

  // idx_q stays on the last byte after RESP, so tx_char holds between responses.
  always_comb begin
    link.tx_xmit = (state_q == StResp);
    link.tx_char = resp_q[idx_q];
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_cmd_responder.sv
// Self-checking bench for cmd_responder: protocol-level model plus per-cycle comparison,
// with literal checks on the captured byte stream.
module tb_cmd_responder;

  localparam int unsigned NCTRL = 8;
  localparam int unsigned NSTAT = 8;
  localparam int unsigned TMO   = 64;

  typedef struct {
    int         cyc;
    logic [7:0] b;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [16*NSTAT-1:0] status;
  logic [16*NCTRL-1:0] ctrl_regs;
  logic                wr_strobe;
  logic [3:0]          wr_addr;

  cmd_responder_if link ();

  cmd_responder #(
    .NCTRL (NCTRL),
    .NSTAT (NSTAT)
`ifdef CMD_TIMEOUT_EN
    ,
    .TIMEOUT (TMO)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .link      (link.slave),
    .status_in (status),
    .ctrl_regs (ctrl_regs),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [16*NCTRL-1:0] ctrl_m;
  logic [7:0]          last_char;
  logic [3:0]          last_wa;
  exp_t                exp_q[$];
  int                  wstage;
  logic [7:0]          wcmd, whi;
  logic                pend_v;
  int                  pend_cyc, pend_a;
  logic [15:0]         pend_d;
  logic                chk_en;

  task automatic model_reset();
    ctrl_m    = '0;
    last_char = 8'h00;
    last_wa   = 4'h0;
    exp_q.delete();
    wstage    = 0;
    pend_v    = 1'b0;
  endtask

  task automatic push(input int c, input logic [7:0] b);
    exp_t e;
    e.cyc = c;
    e.b   = b;
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] model_read(input int a);
    if (a < int'(NCTRL)) return ctrl_m[16*a +: 16];
    if (a < int'(NCTRL + NSTAT)) return status[16*(a-int'(NCTRL)) +: 16];
    return 16'h0000;
  endfunction

  // Byte accepted by the DUT at the end of cycle c
  task automatic model_accept(input logic [7:0] b, input int c);
    logic [15:0] d;
    case (wstage)
      0: begin
        if (b[5:4] != 2'b00 || b[7:6] == 2'b11) begin
          push(c + 1, 8'hEE);
        end else if (b[7:6] == 2'b01) begin
          wcmd   = b;
          wstage = 1;
        end else if (b[7:6] == 2'b10) begin
          push(c + 1, 8'hA5);
        end else begin
          d = model_read(int'(b[3:0]));
          push(c + 1, b);
          push(c + 2, d[15:8]);
          push(c + 3, d[7:0]);
        end
      end
      1: begin
        whi    = b;
        wstage = 2;
      end
      default: begin
        wstage = 0;
        if (int'(wcmd[3:0]) < int'(NCTRL)) begin
          pend_v   = 1'b1;
          pend_cyc = c + 1;
          pend_a   = int'(wcmd[3:0]);
          pend_d   = {whi, b};
          push(c + 1, wcmd);
        end else begin
          push(c + 1, 8'hEE);
        end
      end
    endcase
  endtask

  // ---------------- per-cycle compare ----------------
  logic exp_ws;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_ws = 1'b0;
      if (pend_v && pend_cyc == cyc) begin
        ctrl_m[16*pend_a +: 16] = pend_d;
        last_wa = 4'(pend_a);
        pend_v  = 1'b0;
        exp_ws  = 1'b1;
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("tx_xmit", 128'(link.tx_xmit), 128'(1'b1));
        check("tx_char", 128'(link.tx_char), 128'(exp_q[0].b));
        last_char = exp_q[0].b;
        void'(exp_q.pop_front());
      end else begin
        check("tx_xmit_idle", 128'(link.tx_xmit), 128'(1'b0));
        check("tx_char_hold", 128'(link.tx_char), 128'(last_char));
      end
      check("wr_strobe", 128'(wr_strobe), 128'(exp_ws));
      check("wr_addr", 128'(wr_addr), 128'(last_wa));
      check("ctrl_regs", 128'(ctrl_regs), 128'(ctrl_m));
    end
  end

  // Raw capture of pushed bytes, used by the literal checks
  logic [7:0] txlog[$];
  always @(negedge clk) begin
    if (rst_n && link.tx_xmit) txlog.push_back(link.tx_char);
  end

  task automatic expect_log(input string name, input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] e [3];
    e[0] = b0;
    e[1] = b1;
    e[2] = b2;
    check({name, "_len"}, 128'(txlog.size()), 128'(n));
    for (int i = 0; i < n && i < txlog.size(); i++) begin
      check($sformatf("%s_b%0d", name, i), 128'(txlog[i]), 128'(e[i]));
    end
    txlog.delete();
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    link.rx_strobe = 1'b1;
    link.rx_byte   = b;
    model_accept(b, cyc);
    @(posedge clk);
    #1;
    link.rx_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_xmit"}, 128'(link.tx_xmit), 128'(1'b0));
    check({name, "_char"}, 128'(link.tx_char), 128'(8'h00));
    check({name, "_wrs"}, 128'(wr_strobe), 128'(1'b0));
    check({name, "_wra"}, 128'(wr_addr), 128'(4'h0));
    check({name, "_ctrl"}, 128'(ctrl_regs), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    chk_en         = 1'b0;
    link.rx_strobe = 1'b0;
    link.rx_byte   = 8'h00;
    status         = '0;
    model_reset();
    #2;
    check_reset_outputs("reset");
    #20;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    send(8'h00);
    idle(5);
    expect_log("read00", 3, 8'h00, 8'h00, 8'h00);

    send(8'h43);
    send(8'h12);
    send(8'h34);
    idle(3);
    expect_log("wr43", 1, 8'h43, 8'h00, 8'h00);
    check("reg3_lit", 128'(ctrl_regs[63:48]), 128'(16'h1234));
    check("wr_addr_lit", 128'(wr_addr), 128'(4'h3));
    send(8'h03);
    idle(5);
    expect_log("read03", 3, 8'h03, 8'h12, 8'h34);

    status[47:32] = 16'hBEEF;
    send(8'h0A);
    status[47:32] = 16'h0000;  // must not affect the response already sampled
    idle(5);
    expect_log("read0A", 3, 8'h0A, 8'hBE, 8'hEF);

    send(8'h4A);
    send(8'h00);
    send(8'h01);
    idle(3);
    expect_log("wr4A_nak", 1, 8'hEE, 8'h00, 8'h00);

    send(8'h80);
    idle(3);
    expect_log("ping", 1, 8'hA5, 8'h00, 8'h00);
    send(8'hC0);
    idle(3);
    expect_log("rsvd_op", 1, 8'hEE, 8'h00, 8'h00);
    send(8'h10);
    idle(3);
    expect_log("rsvd_bits", 1, 8'hEE, 8'h00, 8'h00);

    send(8'h41);
    send(8'hAA);
`ifdef CMD_TIMEOUT_EN
    chk_en = 1'b0;
    idle(TMO + 10);
    expect_log("timeout", 1, 8'hEE, 8'h00, 8'h00);
    wstage    = 0;
    last_char = 8'hEE;
    chk_en    = 1'b1;
    check("reg1_untouched", 128'(ctrl_regs[31:16]), 128'(16'h0000));
    send(8'h80);
    idle(3);
    expect_log("ping_after_tmo", 1, 8'hA5, 8'h00, 8'h00);
`else
    idle(TMO + 10);
    expect_log("stall_silent", 0, 8'h00, 8'h00, 8'h00);
    send(8'h55);
    idle(3);
    expect_log("late_lo", 1, 8'h41, 8'h00, 8'h00);
    check("reg1_late", 128'(ctrl_regs[31:16]), 128'(16'hAA55));
`endif

    send(8'h42);
    send(8'hAA);
    #3;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    txlog.delete();
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    send(8'h01);
    idle(5);
    expect_log("read01", 3, 8'h01, 8'h00, 8'h00);
    check("ctrl_after_reset", 128'(ctrl_regs), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_responder.md
# cmd_responder

Byte-level command responder sitting between `serialrx` and `serialtx` on the RS422 command link. Parses single-byte and three-byte commands from the cRIO, reads/writes a bank of 16-bit control registers and reads 16-bit status inputs. It answers each command with 1–3 response bytes pushed into the transmitter FIFO.

## Interface
- `NCTRL`, 8: number of read/write control registers, addresses 0..NCTRL-1 (NCTRL+NSTAT ≤ 16).
- `NSTAT`, 8: number of read-only status words, addresses NCTRL..NCTRL+NSTAT-1.
- `TIMEOUT`, 65535: inter-byte timeout in clk cycles, used only with `CMD_TIMEOUT_EN`.
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx_strobe`  in  1  one-cycle new-byte strobe (serialrx `newrxstrobe`).
- `rx_byte`  in  8  received byte, valid with `rx_strobe`.
- `tx_xmit`  out  1  one-cycle push into serialtx FIFO.
- `tx_char`  out  8  byte pushed, valid with `tx_xmit`.
- `status_in`  in  16*NSTAT  status words, word k at bits [16k+15:16k].
- `ctrl_regs`  out  16*NCTRL  control registers, same packing.
- `wr_strobe`  out  1  one cycle after any control register write.
- `wr_addr`  out  4  address of the last write.

## Operation
- Command byte: [7:6] opcode, [5:4] must be 00, [3:0] address.
- 00 READ: response = cmd echo, data[15:8], data[7:0]. Data comes from the control register or the status word. An unmapped address reads 0x0000.
- 01 WRITE: two more bytes follow, hi then lo. After lo: if addr < NCTRL, write the register, pulse `wr_strobe`, respond with cmd echo. Otherwise respond NAK 0xEE with no write.
- 10 PING: respond 0xA5.
- 11, or [5:4] ≠ 00: respond NAK 0xEE.
- FSM states: IDLE, WR_HI, WR_LO, RESP.
  - IDLE goes to WR_HI on a WRITE byte. Any other byte loads the response buffer and goes to RESP.
  - WR_HI latches hi and goes to WR_LO.
  - WR_LO latches lo, performs the write, loads the response and goes to RESP.
  - RESP emits one byte per cycle from a 3-entry buffer. It returns to IDLE the cycle after the last byte.
- `rx_strobe` in RESP is ignored. This cannot happen with serialrx, because bytes arrive at least about 1000 cycles apart.
- Read data is sampled on the cycle the READ byte is accepted. Later changes to `status_in` do not affect that response.
- No backpressure. Each response is at most 3 bytes, which the serialtx FIFO absorbs.
- Reset values: `ctrl_regs` 0, `tx_xmit` 0, `tx_char` 0x00, `wr_strobe` 0, `wr_addr` 0, state IDLE.
- Reset mid-operation discards any partial WRITE and any unsent response bytes.

## Timing
- `rx_strobe` of READ at cycle N: `tx_xmit` high at N+1, N+2, N+3 with echo, hi, lo.
- PING or NAK at N: one byte at N+1.
- Final WRITE byte at N: `ctrl_regs` updated, `wr_strobe` high and `wr_addr` valid at N+1, ack byte at N+1.
- Ready for the next command at N+2 after a 1-byte response, or N+4 after a READ.
- `tx_char` holds its last value when `tx_xmit` is 0.

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - A counter runs in WR_HI/WR_LO and restarts on each accepted byte.
  - After TIMEOUT cycles with no byte, the FSM aborts, emits NAK 0xEE once and returns to IDLE.
  - No register is written on abort.
  - Counter width is $clog2(TIMEOUT+1).
- `CMD_TIMEOUT_EN` undefined:
  - WR_HI/WR_LO wait indefinitely and no counter is built.
  - Only reset clears a stalled WRITE.

## Structure
- Shared package `cmd_pkg`:
  - opcode constants OP_READ/OP_WRITE/OP_PING/OP_RSVD;
  - response constants PING_RESP 0xA5, NAK 0xEE;
  - state enum for IDLE/WR_HI/WR_LO/RESP.
- Sub-module `cmd_regbank`:
  - NCTRL×16 flops with async reset, a write port and combinational read mux over ctrl + status;
  - `cmd_responder` instantiates it once.

## Test plan
- After reset, READ 0x00: bytes 0x00,0x00,0x00 on consecutive cycles N+1..N+3; `ctrl_regs` all zero.
- WRITE 0x43, 0x12, 0x34 then READ 0x03: ack 0x43 at N+1, `wr_strobe` with `wr_addr`=3, `ctrl_regs[63:48]`=0x1234; read returns 0x03,0x12,0x34.
- `status_in` word 2 = 0xBEEF, READ 0x0A: returns 0x0A,0xBE,0xEF. WRITE 0x4A,0x00,0x01 returns 0xEE with no `wr_strobe`.
- PING 0x80 → single 0xA5. Byte 0xC0 → 0xEE. Byte 0x10 → 0xEE.
- WRITE 0x41, 0xAA, then silence for TIMEOUT+10 cycles:
  - with `CMD_TIMEOUT_EN`: one 0xEE, register 1 unchanged, and the next PING answers 0xA5;
  - without it: no output, and the next byte is taken as lo.
- Assert `rst_n` low between WRITE hi and lo bytes: all outputs return to reset values immediately, and a following READ 0x01 returns 0x01,0x00,0x00.
